// File: rtl/bcd_score_counter.sv
// Multi-digit BCD up/down score counter with wrap/saturate, sticky win and wrap pulse.
// Optional build macro BCD_SCORE_EDGE_EN: inc/dec become rising-edge detected.
module bcd_score_counter #(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned WIN_SCORE = 11,
    parameter int unsigned WRAP      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  win,
    output logic                  wrap,
    output logic                  at_zero,
    output logic                  at_max
);

    localparam int unsigned W = 4 * DIGITS;

    // Convert a decimal constant into packed BCD, units digit in the low nibble.
    function automatic logic [W-1:0] to_bcd(input int unsigned value);
        logic [W-1:0] result;
        int unsigned  rest;
        result = '0;
        rest   = value;
        for (int i = 0; i < int'(DIGITS); i++) begin
            result[4*i +: 4] = 4'(rest % 10);
            rest             = rest / 10;
        end
        return result;
    endfunction

    localparam logic [W-1:0] MAX_BCD = {DIGITS{4'h9}};
    localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);
    localparam bit           WIN_EN  = (WIN_SCORE != 0);
    localparam bit           WRAP_EN = (WRAP != 0);

    logic         inc_req;
    logic         dec_req;
    logic         up;
    logic         down;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] next_val;
    logic         step;
    logic         wrap_hit;
    logic         win_hit;
    logic         carry;
    logic         borrow;

`ifdef BCD_SCORE_EDGE_EN
    logic inc_q;
    logic dec_q;

    // One register stage per request so a held level yields a single step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
        end
    end

    assign inc_req = inc & ~inc_q;
    assign dec_req = dec & ~dec_q;
`else
    assign inc_req = inc;
    assign dec_req = dec;
`endif

    assign up      = en & inc_req & ~dec_req;
    assign down    = en & dec_req & ~inc_req;
    assign at_zero = (digits == '0);
    assign at_max  = (digits == MAX_BCD);

    // Ripple-carry increment and ripple-borrow decrement across the BCD digits.
    always_comb begin
        inc_val = digits;
        dec_val = digits;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (digits[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = 4'(digits[4*i +: 4] + 4'd1);
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (digits[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = 4'(digits[4*i +: 4] - 4'd1);
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Choose the next value; range ends either wrap (with a pulse) or saturate.
    always_comb begin
        step     = 1'b0;
        wrap_hit = 1'b0;
        next_val = digits;
        if (up) begin
            if (!at_max) begin
                step     = 1'b1;
                next_val = inc_val;
            end else if (WRAP_EN) begin
                step     = 1'b1;
                wrap_hit = 1'b1;
                next_val = '0;
            end
        end else if (down) begin
            if (!at_zero) begin
                step     = 1'b1;
                next_val = dec_val;
            end else if (WRAP_EN) begin
                step     = 1'b1;
                wrap_hit = 1'b1;
                next_val = MAX_BCD;
            end
        end
        win_hit = WIN_EN && (next_val == WIN_BCD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits <= '0;
            win    <= 1'b0;
            wrap   <= 1'b0;
        end else if (clr) begin
            digits <= '0;
            win    <= 1'b0;
            wrap   <= 1'b0;
        end else if (win) begin
            wrap <= 1'b0;
        end else if (step) begin
            digits <= next_val;
            wrap   <= wrap_hit;
            win    <= win_hit;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed self-checking bench for bcd_score_counter in three parameter sets sharing one stimulus.
module tb_bcd_score_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       inc;
    logic       dec;
    logic       clr;

    // a: WIN_SCORE=11 WRAP=1, b: WIN_SCORE=0 WRAP=1, c: WIN_SCORE=0 WRAP=0
    logic [7:0] digits_a, digits_b, digits_c;
    logic       win_a, win_b, win_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       at_zero_a, at_zero_b, at_zero_c;
    logic       at_max_a, at_max_b, at_max_c;

    int checks = 0;
    int errors = 0;

    bcd_score_counter #(.DIGITS(2), .WIN_SCORE(11), .WRAP(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .clr(clr),
        .digits(digits_a), .win(win_a), .wrap(wrap_a), .at_zero(at_zero_a), .at_max(at_max_a)
    );

    bcd_score_counter #(.DIGITS(2), .WIN_SCORE(0), .WRAP(1)) u_b (
        .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .clr(clr),
        .digits(digits_b), .win(win_b), .wrap(wrap_b), .at_zero(at_zero_b), .at_max(at_max_b)
    );

    bcd_score_counter #(.DIGITS(2), .WIN_SCORE(0), .WRAP(0)) u_c (
        .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .clr(clr),
        .digits(digits_c), .win(win_c), .wrap(wrap_c), .at_zero(at_zero_c), .at_max(at_max_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b1; inc = 1'b0; dec = 1'b0; clr = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_inc();
        inc = 1'b1;
        tick();
        inc = 1'b0;
        tick();
    endtask

    task automatic pulse_dec();
        dec = 1'b1;
        tick();
        dec = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
        #1;
        checks++;
        if ({digits_a, win_a, wrap_a, at_zero_a, at_max_a} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got digits=%h win=%b wrap=%b at_zero=%b at_max=%b, want 00 0 0 1 0",
                     digits_a, win_a, wrap_a, at_zero_a, at_max_a);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_count_to_win();
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            inc = 1'b1;
            tick();
            inc = 1'b0;
            checks++;
            if (digits_a !== bcd(k > 11 ? 11 : k)) begin
                errors++;
                $display("FAIL count_inc_%0d: got %h, want %h", k, digits_a, bcd(k > 11 ? 11 : k));
            end
            checks++;
            if (win_a !== (k >= 11)) begin
                errors++;
                $display("FAIL win_inc_%0d: got %b, want %b", k, win_a, (k >= 11));
            end
            tick();
        end
    endtask

    task automatic test_clear_and_both();
        clr = 1'b1; inc = 1'b1;
        tick();
        clr = 1'b0; inc = 1'b0;
        checks++;
        if ({digits_a, win_a} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL clear: got digits=%h win=%b, want 00 0", digits_a, win_a);
        end
        tick();
        inc = 1'b1; dec = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({digits_a, wrap_a} !== {8'h00, 1'b0}) begin
                errors++;
                $display("FAIL both_req_%0d: got digits=%h wrap=%b, want 00 0", k, digits_a, wrap_a);
            end
        end
        inc = 1'b0; dec = 1'b0;
        tick();
    endtask

    task automatic test_decrement();
        do_reset();
        for (int k = 0; k < 10; k++) pulse_inc();
        checks++;
        if (digits_a !== 8'h10) begin
            errors++;
            $display("FAIL dec_setup: got %h, want 10", digits_a);
        end
        dec = 1'b1;
        tick();
        dec = 1'b0;
        checks++;
        if ({digits_a, at_zero_a, wrap_a} !== {8'h09, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dec_borrow: got digits=%h at_zero=%b wrap=%b, want 09 0 0", digits_a, at_zero_a, wrap_a);
        end
        tick();
    endtask

    task automatic test_wrap_and_saturate();
        do_reset();
        for (int k = 0; k < 99; k++) pulse_inc();
        checks++;
        if ({digits_b, at_max_b, digits_c, at_max_c} !== {8'h99, 1'b1, 8'h99, 1'b1}) begin
            errors++;
            $display("FAIL load_99: got b=%h/%b c=%h/%b, want 99/1 99/1", digits_b, at_max_b, digits_c, at_max_c);
        end
        inc = 1'b1;
        tick();
        inc = 1'b0;
        checks++;
        if ({digits_b, wrap_b, at_zero_b} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_up: got digits=%h wrap=%b at_zero=%b, want 00 1 1", digits_b, wrap_b, at_zero_b);
        end
        checks++;
        if ({digits_c, wrap_c, at_max_c} !== {8'h99, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sat_up: got digits=%h wrap=%b at_max=%b, want 99 0 1", digits_c, wrap_c, at_max_c);
        end
        tick();
        checks++;
        if ({digits_b, wrap_b} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL wrap_up_width: got digits=%h wrap=%b, want 00 0", digits_b, wrap_b);
        end
        dec = 1'b1;
        tick();
        dec = 1'b0;
        checks++;
        if ({digits_b, wrap_b, digits_c} !== {8'h99, 1'b1, 8'h98}) begin
            errors++;
            $display("FAIL wrap_down: got b=%h wrap=%b c=%h, want 99 1 98", digits_b, wrap_b, digits_c);
        end
        tick();
        checks++;
        if (wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down_width: got wrap=%b, want 0", wrap_b);
        end
        do_reset();
        dec = 1'b1;
        tick();
        dec = 1'b0;
        checks++;
        if ({digits_c, wrap_c, at_zero_c} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sat_down: got digits=%h wrap=%b at_zero=%b, want 00 0 1", digits_c, wrap_c, at_zero_c);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 7; k++) pulse_inc();
        checks++;
        if (digits_a !== 8'h07) begin
            errors++;
            $display("FAIL areset_setup: got %h, want 07", digits_a);
        end
        inc = 1'b1;
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({digits_a, win_a} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: got digits=%h win=%b, want 00 0", digits_a, win_a);
        end
        inc = 1'b0;
        #2 reset = 1'b0;
        tick();
        checks++;
        if (digits_a !== 8'h00) begin
            errors++;
            $display("FAIL areset_release: got %h, want 00", digits_a);
        end
    endtask

    task automatic test_held_inc();
        logic [7:0] want;
`ifdef BCD_SCORE_EDGE_EN
        want = 8'h01;
`else
        want = 8'h05;
`endif
        do_reset();
        inc = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        inc = 1'b0;
        checks++;
        if (digits_a !== want) begin
            errors++;
            $display("FAIL held_inc: got %h, want %h", digits_a, want);
        end
        do_reset();
        en = 1'b0;
        inc = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        inc = 1'b0;
        checks++;
        if (digits_a !== 8'h00) begin
            errors++;
            $display("FAIL held_inc_disabled: got %h, want 00", digits_a);
        end
        en = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_count_to_win();
        test_clear_and_both();
        test_decrement();
        test_wrap_and_saturate();
        test_async_reset();
        test_held_inc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_score_counter.md
Name: bcd_score_counter

Overview:
Parametrised multi-digit BCD up/down counter for score keeping and display. Drives the seven-segment digit mux directly: each digit is one 4-bit BCD nibble and is never above 9. Adds decrement, clear, wrap-or-saturate mode, a sticky win flag and a wrap pulse. Sits between the collision/goal logic (inc/dec requests) and the display and game FSM (digits, win).

Parameters:
DIGITS, 2, number of BCD digits; the counter range is 0 to 10^DIGITS-1.
WIN_SCORE, 11, decimal value that sets win; 0 disables win detection; must be <= 10^DIGITS-1.
WRAP, 1, 1 = wrap at the range ends; 0 = saturate at 0 and at 10^DIGITS-1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
en  in  1  count enable; gates inc and dec only.
inc  in  1  increment request.
dec  in  1  decrement request.
clr  in  1  synchronous clear; independent of en.
digits  out  4*DIGITS  BCD value; digit 0 (units) is in bits [3:0].
win  out  1  sticky; set when the count reaches WIN_SCORE.
wrap  out  1  one-cycle pulse when a wrap occurs.
at_zero  out  1  combinational: count == 0.
at_max  out  1  combinational: every digit == 9.

Behaviour:
- Reset (async, high): digits=0, win=0, wrap=0, internal edge registers=0. Reset acts mid-operation with no pending update.
- All updates happen on rising clk; latency is 1 cycle from the request to the new digits.
- Priority: reset > clr > win freeze > (inc,dec).
- clr=1: digits=0, win=0, wrap=0 on the next edge, regardless of en, inc or dec.
- Freeze: while win=1, inc and dec are ignored and digits hold. Only clr or reset leaves the win state.
- Effective step: a step occurs only when en=1 and exactly one of inc/dec is active.
  - inc and dec both active, or en=0: digits hold, wrap=0.
- Increment is a ripple-carry BCD add. A digit at 9 goes to 0 and carries into the next digit.
  - Example: 09 -> 10, 99 -> 00.
- Decrement is a ripple-borrow BCD subtract. A digit at 0 goes to 9 and borrows from the next digit.
  - Example: 10 -> 09.
- Upper range end (all 9s) with inc:
  - WRAP=1: go to 0 and pulse wrap=1 for exactly one cycle.
  - WRAP=0: hold, wrap=0.
- Lower range end (0) with dec:
  - WRAP=1: go to all 9s and pulse wrap=1.
  - WRAP=0: hold at 0, wrap=0.
- wrap is a registered output and is 0 in every cycle without a wrap step.
- win is set on the edge where the next value equals WIN_SCORE, whether reached by inc or by dec. It is registered together with digits, so both change in the same cycle.
- If WIN_SCORE=0, win stays 0 permanently.
- A wrap step that lands on WIN_SCORE also sets win; wrap still pulses.
- at_zero and at_max are decoded from the current registered digits.
- No illegal BCD digit codes (A-F) are reachable.

Optional Feature:
Macro BCD_SCORE_EDGE_EN.
- Defined: inc and dec are rising-edge detected internally through one register stage each; those registers are cleared by reset. A held level produces exactly one step, and the request must go low before it can step again.
- Undefined: inc and dec are level-sensitive, giving one step per clock while the request is high and en=1.
- Latency from the input edge to digits is 1 cycle in both builds.

Test Plan:
1. Reset, then 12 single-cycle inc pulses with en=1 (DIGITS=2, WIN_SCORE=11) -> digits reads 01,02...09,10,11. win=1 on the edge where 11 appears. The 12th inc is ignored: digits stays 11.
2. Drive clr with inc high -> digits=00 and win=0 on the next edge. inc=1, dec=1, en=1 for 3 cycles -> digits stays 00, wrap=0.
3. WRAP=1, WIN_SCORE=0, load 99 via 99 incs, then inc -> digits=00, wrap high for exactly 1 cycle. Then dec -> digits=99, wrap pulses again.
4. WRAP=0: inc at 99 -> stays 99, wrap=0, at_max=1. dec from 00 -> stays 00, at_zero=1.
5. Assert reset asynchronously mid-clock at count 07 with inc high -> digits=00 and win=0 immediately. No step on the first edge after release if inc is low.
6. Hold inc high for 5 cycles, en=1 -> with BCD_SCORE_EDGE_EN defined digits=01; undefined digits=05. en=0 throughout -> digits=00 in both builds.
